// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer, auto-increment and fabric-side
// register write strobes / read pointer. SCL is input-only (no clock stretching).
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR   = 7'h70,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK,
    ST_IGNORE
  } state_t;

  localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);

  logic       scl_s1, scl_s2, sda_s1, sda_s2;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic [3:0] scl_cnt, sda_cnt;

  // Synchroniser and glitch filter; everything downstream sees scl_f/sda_f only.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      scl_s1  <= 1'b1;
      scl_s2  <= 1'b1;
      sda_s1  <= 1'b1;
      sda_s2  <= 1'b1;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      scl_q  <= scl_f;
      sda_q  <= sda_f;

      if (scl_s2 == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FLT_MAX) begin
        scl_f   <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end

      if (sda_s2 == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FLT_MAX) begin
        sda_f   <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  state_t     state, state_n;
  logic [7:0] shift, shift_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic       rw, rw_n;
  logic       mack_ok, mack_ok_n;
  logic       sda_oe_n, wr_en_n, busy_n;
  logic [7:0] wr_addr_n, wr_data_n, rd_addr_n;
  logic [7:0] rx_byte;
  logic       rx_bit;

  assign rx_byte = {shift[6:0], sda_f};
  assign rx_bit  = scl_rise && (bit_cnt < 4'd8);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      rw      <= 1'b0;
      mack_ok <= 1'b0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_addr <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      rw      <= rw_n;
      mack_ok <= mack_ok_n;
      sda_oe  <= sda_oe_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      rd_addr <= rd_addr_n;
      busy    <= busy_n;
    end
  end

  // Received bytes finish on the 8th SCL rise (bit_cnt becomes 8); the ACK
  // phase then starts at the following SCL fall.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    rw_n      = rw;
    mack_ok_n = mack_ok;
    sda_oe_n  = sda_oe;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    rd_addr_n = rd_addr;
    busy_n    = busy;

    if (stop_det) begin
      state_n   = ST_IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
      mack_ok_n = 1'b0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
      mack_ok_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ADDR: begin
          if (rx_bit) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                busy_n = 1'b1;
                rw_n   = rx_byte[0];
              end else begin
                busy_n  = 1'b0;
                state_n = ST_IGNORE;
              end
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (rw) begin
              shift_n  = rd_data;
              sda_oe_n = ~rd_data[7];
              state_n  = ST_RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = ST_REG;
            end
          end
        end
        ST_REG: begin
          if (rx_bit) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) rd_addr_n = rx_byte;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = ST_REG_ACK;
          end
        end
        ST_REG_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (rx_bit) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              wr_en_n   = 1'b1;
              wr_addr_n = rd_addr;
              wr_data_n = rx_byte;
              rd_addr_n = rd_addr + 8'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = ST_WDATA_ACK;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              mack_ok_n = 1'b0;
              state_n   = ST_MACK;
            end else if (bit_cnt != 4'd0) begin
              shift_n  = {shift[6:0], 1'b0};
              sda_oe_n = ~shift[6];
            end
          end
        end
        ST_MACK: begin
          if (scl_rise && !mack_ok) begin
            rd_addr_n = rd_addr + 8'd1;
            if (!sda_f) begin
              mack_ok_n = 1'b1;
            end else begin
              busy_n  = 1'b0;
              state_n = ST_IGNORE;
            end
          end else if (scl_fall && mack_ok) begin
            shift_n   = rd_data;
            sda_oe_n  = ~rd_data[7];
            bit_cnt_n = '0;
            mack_ok_n = 1'b0;
            state_n   = ST_RDATA;
          end
        end
        ST_IGNORE: sda_oe_n = 1'b0;
        default:   state_n  = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged initiator drives the bus,
// write strobes and read bytes are checked against scoreboard queues.
module tb_i2c_target_regs;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  assign sda_line = sda_m & ~sda_oe;

  always #10 CLK = ~CLK;

  i2c_target_regs #(
    .DEV_ADDR   (7'h70),
    .FILTER_LEN (3)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .scl_i   (scl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // Fabric register model: registered lookup, one CLK behind the pointer.
  always @(posedge CLK) rd_data <= rd_addr ^ 8'h5A;

  always @(negedge CLK) begin
    logic [15:0] want;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (wr_en) begin
      vectors++;
      if (exp_wr.size() == 0) begin
        assert (1'b0) else begin
          miscompares++;
          $error("FAIL wr_unexpected observed=%h/%h expected=none", wr_addr, wr_data);
        end
      end else begin
        want = exp_wr.pop_front();
        assert ({wr_addr, wr_data} === want) else begin
          miscompares++;
          $error("FAIL wr_strobe observed=%h expected=%h", {wr_addr, wr_data}, want);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; tick(20);
    scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    tick(10); sda_m = 1'b1;
    tick(10); scl = 1'b1;
    tick(20); sda_m = 1'b0;
    tick(20); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(10); sda_m = 1'b0;
    tick(10); scl = 1'b1;
    tick(20); sda_m = 1'b1;
    tick(20);
  endtask

  task automatic write_bit(input logic b);
    tick(10); sda_m = b;
    tick(10); scl = 1'b1;
    tick(20); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    tick(10); sda_m = 1'b1;
    tick(10); scl = 1'b1;
    tick(10); b = sda_line;
    tick(10); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic ack);
    logic [7:0] d;
    logic       b;
    logic [7:0] want;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
    vectors++;
    if (exp_rd.size() == 0) begin
      assert (1'b0) else begin
        miscompares++;
        $error("FAIL rd_unexpected observed=%h expected=none", d);
      end
    end else begin
      want = exp_rd.pop_front();
      assert (d === want) else begin
        miscompares++;
        $error("FAIL rd_byte observed=%h expected=%h", d, want);
      end
    end
  endtask

  task automatic glitch_scl();
    tick(10); sda_m = 1'b1;
    tick(5);  scl = 1'b1;
    tick(2);  scl = 1'b0;
    tick(20);
  endtask

  initial begin
    logic ack;
    RSTn = 1'b0;
    tick(5);
    check("rst_sda_oe", 16'(sda_oe), 16'h0);
    check("rst_wr_en", 16'(wr_en), 16'h0);
    check("rst_wr_addr", 16'(wr_addr), 16'h0);
    check("rst_wr_data", 16'(wr_data), 16'h0);
    check("rst_rd_addr", 16'(rd_addr), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    RSTn = 1'b1;
    tick(10);

    // Register write with auto-increment
    exp_wr.push_back(16'h10AB);
    exp_wr.push_back(16'h11CD);
    i2c_start();
    send_byte(8'hE0, ack); check("wr_ack_addr", 16'(ack), 16'h0);
    send_byte(8'h10, ack); check("wr_ack_reg", 16'(ack), 16'h0);
    send_byte(8'hAB, ack); check("wr_ack_d0", 16'(ack), 16'h0);
    send_byte(8'hCD, ack); check("wr_ack_d1", 16'(ack), 16'h0);
    check("wr_busy", 16'(busy), 16'h1);
    i2c_stop();
    check("wr_busy_stop", 16'(busy), 16'h0);
    check("wr_rd_addr", 16'(rd_addr), 16'h12);
    check("wr_pending", 16'(exp_wr.size()), 16'h0);

    // Pointer set, repeated START, three-byte read
    exp_rd.push_back(8'h7A);
    exp_rd.push_back(8'h7B);
    exp_rd.push_back(8'h78);
    i2c_start();
    send_byte(8'hE0, ack); check("rd_ack_addr", 16'(ack), 16'h0);
    send_byte(8'h20, ack); check("rd_ack_reg", 16'(ack), 16'h0);
    i2c_rstart();
    send_byte(8'hE1, ack); check("rd_ack_addr_r", 16'(ack), 16'h0);
    recv_byte(1'b0);
    recv_byte(1'b0);
    recv_byte(1'b1);
    check("rd_busy_nack", 16'(busy), 16'h0);
    i2c_stop();
    check("rd_rd_addr", 16'(rd_addr), 16'h23);
    check("rd_pending", 16'(exp_rd.size()), 16'h0);

    // Foreign address must be ignored
    oe_cnt = 0;
    busy_cnt = 0;
    i2c_start();
    send_byte(8'hA0, ack); check("na_ack_addr", 16'(ack), 16'h1);
    send_byte(8'h00, ack); check("na_ack_reg", 16'(ack), 16'h1);
    i2c_stop();
    check("na_oe_cnt", 16'(oe_cnt), 16'h0);
    check("na_busy_cnt", 16'(busy_cnt), 16'h0);
    check("na_rd_addr", 16'(rd_addr), 16'h23);

    // Pointer wraps through 0xFF
    exp_wr.push_back(16'hFE01);
    exp_wr.push_back(16'hFF02);
    exp_wr.push_back(16'h0003);
    i2c_start();
    send_byte(8'hE0, ack);
    send_byte(8'hFE, ack);
    send_byte(8'h01, ack);
    send_byte(8'h02, ack);
    send_byte(8'h03, ack); check("wrap_ack", 16'(ack), 16'h0);
    i2c_stop();
    check("wrap_rd_addr", 16'(rd_addr), 16'h01);
    check("wrap_pending", 16'(exp_wr.size()), 16'h0);

    // Short SCL pulse must not be taken as a clock
    exp_wr.push_back(16'h4055);
    i2c_start();
    send_byte(8'hE0, ack);
    glitch_scl();
    send_byte(8'h40, ack); check("glitch_ack", 16'(ack), 16'h0);
    send_byte(8'h55, ack);
    i2c_stop();
    check("glitch_rd_addr", 16'(rd_addr), 16'h41);
    check("glitch_pending", 16'(exp_wr.size()), 16'h0);

    // STOP mid-byte discards the partial byte
    i2c_start();
    send_byte(8'hE0, ack);
    send_byte(8'h50, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    check("abort_rd_addr", 16'(rd_addr), 16'h50);
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_sda_oe", 16'(sda_oe), 16'h0);

    // Reset during the address ACK releases SDA on the next edge
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'hE0 >> i));
    tick(10);
    check("rsta_ack_driven", 16'(sda_oe), 16'h1);
    RSTn = 1'b0;
    tick(1);
    check("rsta_sda_oe", 16'(sda_oe), 16'h0);
    check("rsta_busy", 16'(busy), 16'h0);
    check("rsta_rd_addr", 16'(rd_addr), 16'h0);
    RSTn = 1'b1;
    tick(10); sda_m = 1'b0;
    tick(10); scl = 1'b1;
    tick(20); sda_m = 1'b1;
    tick(20);
    check("final_wr_pending", 16'(exp_wr.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
